// File: rtl/sys_ctrl_cmd_decoder_if.sv
// rtl/sys_ctrl_cmd_decoder_if.sv - RX byte stream and register/ALU control bundle of the command decoder
interface sys_ctrl_cmd_decoder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) ();
  logic [DATA_WIDTH-1:0] RX_P_DATA;
  logic                  RX_D_VLD;
  logic                  RX_ERR;
  logic                  WrEn;
  logic                  RdEn;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] WrData;
  logic                  ALU_EN;
  logic [FUN_WIDTH-1:0]  ALU_FUN;
  logic                  CLK_GATE_EN;
  logic                  BUSY;
  logic                  CMD_ERR;
  logic                  TIMEOUT;

  modport master (
    output RX_P_DATA, RX_D_VLD, RX_ERR,
    input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, BUSY, CMD_ERR, TIMEOUT
  );

  modport slave (
    input  RX_P_DATA, RX_D_VLD, RX_ERR,
    output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, BUSY, CMD_ERR, TIMEOUT
  );
endinterface

// File: rtl/sys_ctrl_cmd_decoder.sv
// rtl/sys_ctrl_cmd_decoder.sv - UART RX command parser driving register-file and ALU strobes
// Optional inter-byte timeout enabled by defining SYS_CTRL_TIMEOUT_EN.
module sys_ctrl_cmd_decoder #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                   CLK,
  input logic                   RST,
  sys_ctrl_cmd_decoder_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN_S
  } state_t;

  localparam logic [DATA_WIDTH-1:0] OP_WRITE   = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_READ    = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU_OPS = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_ALU     = DATA_WIDTH'(8'hDD);

  state_t                r_state;
  logic                  r_wr_en, r_rd_en, r_alu_en, r_gate, r_busy, r_cmd_err;
  logic [ADDR_WIDTH-1:0] r_addr, r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [FUN_WIDTH-1:0]  r_alu_fun;
  logic [DATA_WIDTH-1:0] w_byte;

  assign w_byte = bus.RX_P_DATA;

`ifdef SYS_CTRL_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_timeout;
  assign bus.TIMEOUT = r_timeout;
`else
  // Constant 0 in this build; the comparison only keeps the shared parameter referenced.
  assign bus.TIMEOUT = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_alu_en  <= 1'b0;
      r_gate    <= 1'b0;
      r_busy    <= 1'b0;
      r_cmd_err <= 1'b0;
      r_addr    <= '0;
      r_wr_addr <= '0;
      r_wdata   <= '0;
      r_alu_fun <= '0;
`ifdef SYS_CTRL_TIMEOUT_EN
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_alu_en  <= 1'b0;
      r_cmd_err <= 1'b0;
      // Gate stays up while waiting for the function byte; branches below override.
      r_gate    <= (r_state == ALU_FUN_S);
`ifdef SYS_CTRL_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      if (bus.RX_D_VLD) begin
`ifdef SYS_CTRL_TIMEOUT_EN
        r_tmo_cnt <= '0;
`endif
        if (bus.RX_ERR) begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_gate    <= 1'b0;
          r_cmd_err <= 1'b1;
        end else begin
          case (r_state)
            IDLE: begin
              case (w_byte)
                OP_WRITE:   begin r_state <= WR_ADDR;   r_busy <= 1'b1; end
                OP_READ:    begin r_state <= RD_ADDR;   r_busy <= 1'b1; end
                OP_ALU_OPS: begin r_state <= ALU_A;     r_busy <= 1'b1; end
                OP_ALU:     begin r_state <= ALU_FUN_S; r_busy <= 1'b1; r_gate <= 1'b1; end
                default:    r_cmd_err <= 1'b1;
              endcase
            end
            WR_ADDR: begin
              r_wr_addr <= w_byte[ADDR_WIDTH-1:0];
              r_state   <= WR_DATA;
            end
            WR_DATA: begin
              r_wr_en <= 1'b1;
              r_addr  <= r_wr_addr;
              r_wdata <= w_byte;
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
            RD_ADDR: begin
              r_rd_en <= 1'b1;
              r_addr  <= w_byte[ADDR_WIDTH-1:0];
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
            ALU_A: begin
              r_wr_en <= 1'b1;
              r_addr  <= '0;
              r_wdata <= w_byte;
              r_state <= ALU_B;
            end
            ALU_B: begin
              r_wr_en <= 1'b1;
              r_addr  <= ADDR_WIDTH'(1);
              r_wdata <= w_byte;
              r_state <= ALU_FUN_S;
              r_gate  <= 1'b1;
            end
            ALU_FUN_S: begin
              r_alu_en  <= 1'b1;
              r_alu_fun <= w_byte[FUN_WIDTH-1:0];
              r_state   <= IDLE;
              r_busy    <= 1'b0;
              r_gate    <= 1'b1;
            end
            default: begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          endcase
        end
      end
`ifdef SYS_CTRL_TIMEOUT_EN
      else if (r_state != IDLE) begin
        if (r_tmo_cnt == TMO_LAST) begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_gate    <= 1'b0;
          r_timeout <= 1'b1;
          r_tmo_cnt <= '0;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
      end
`endif
    end
  end

  assign bus.WrEn        = r_wr_en;
  assign bus.RdEn        = r_rd_en;
  assign bus.Address     = r_addr;
  assign bus.WrData      = r_wdata;
  assign bus.ALU_EN      = r_alu_en;
  assign bus.ALU_FUN     = r_alu_fun;
  assign bus.CLK_GATE_EN = r_gate;
  assign bus.BUSY        = r_busy;
  assign bus.CMD_ERR     = r_cmd_err;
endmodule

// File: tb/tb_sys_ctrl_cmd_decoder.sv
// tb/tb_sys_ctrl_cmd_decoder.sv - directed and randomized bench against a command-buffer reference model
module tb_sys_ctrl_cmd_decoder;
  localparam int TMO = 16;
`ifdef SYS_CTRL_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  sys_ctrl_cmd_decoder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) bus_if ();

  sys_ctrl_cmd_decoder #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus_if)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] pend[$];
  int         silent;
  logic       e_wr, e_rd, e_alu, e_gate, e_busy, e_err, e_tmo;
  logic [3:0] e_addr, e_fun;
  logic [7:0] e_wdata;

  function automatic bit known_op(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hBB) || (b == 8'hCC) || (b == 8'hDD);
  endfunction

  function automatic int cmd_len(input logic [7:0] op);
    case (op)
      8'hAA:   return 3;
      8'hCC:   return 4;
      default: return 2;
    endcase
  endfunction

  // Reference: commands are collected byte by byte and acted on by their length.
  task automatic model(input bit vld, input logic [7:0] d, input bit err);
    logic [7:0] b;
    int n;
    e_wr = 0; e_rd = 0; e_alu = 0; e_err = 0; e_tmo = 0;
    if (vld) begin
      silent = 0;
      if (err) begin
        pend.delete();
        e_err = 1;
      end else if (pend.size() == 0 && !known_op(d)) begin
        e_err = 1;
      end else begin
        pend.push_back(d);
        n = pend.size();
        case (pend[0])
          8'hAA: if (n == 3) begin b = pend[1]; e_addr = b[3:0]; e_wdata = pend[2]; e_wr = 1; end
          8'hBB: if (n == 2) begin b = pend[1]; e_addr = b[3:0]; e_rd = 1; end
          8'hCC: begin
            if (n == 2) begin e_addr = 4'd0; e_wdata = pend[1]; e_wr = 1; end
            if (n == 3) begin e_addr = 4'd1; e_wdata = pend[2]; e_wr = 1; end
            if (n == 4) begin b = pend[3]; e_fun = b[3:0]; e_alu = 1; end
          end
          default: if (n == 2) begin b = pend[1]; e_fun = b[3:0]; e_alu = 1; end
        endcase
        if (n == cmd_len(pend[0])) pend.delete();
      end
    end else if (pend.size() != 0) begin
      silent++;
      if (TMO_ON && silent == TMO) begin
        pend.delete();
        e_tmo = 1;
      end
    end
    e_busy = (pend.size() != 0);
    e_gate = e_alu;
    if (pend.size() != 0)
      if ((pend[0] == 8'hCC && pend.size() == 3) || (pend[0] == 8'hDD && pend.size() == 1))
        e_gate = 1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("WrEn",        8'(bus_if.WrEn),        8'(e_wr));
    check("RdEn",        8'(bus_if.RdEn),        8'(e_rd));
    check("ALU_EN",      8'(bus_if.ALU_EN),      8'(e_alu));
    check("Address",     8'(bus_if.Address),     8'(e_addr));
    check("WrData",      bus_if.WrData,          e_wdata);
    check("ALU_FUN",     8'(bus_if.ALU_FUN),     8'(e_fun));
    check("CLK_GATE_EN", 8'(bus_if.CLK_GATE_EN), 8'(e_gate));
    check("BUSY",        8'(bus_if.BUSY),        8'(e_busy));
    check("CMD_ERR",     8'(bus_if.CMD_ERR),     8'(e_err));
    check("TIMEOUT",     8'(bus_if.TIMEOUT),     8'(e_tmo));
  endtask

  task automatic step(input bit vld, input logic [7:0] d, input bit err);
    bus_if.RX_D_VLD  = vld;
    bus_if.RX_P_DATA = d;
    bus_if.RX_ERR    = err;
    model(vld, d, err);
    @(posedge CLK); #1;
    check_all();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus_if.RX_D_VLD = 1'b0; bus_if.RX_P_DATA = 8'h00; bus_if.RX_ERR = 1'b0;
    pend.delete(); silent = 0;
    e_wr = 0; e_rd = 0; e_alu = 0; e_gate = 0; e_busy = 0; e_err = 0; e_tmo = 0;
    e_addr = 0; e_fun = 0; e_wdata = 0;
    @(posedge CLK); #1;
    RST = 1'b0;
    check_all();
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
  endtask

  initial begin
    logic [7:0] ops[4];
    logic [7:0] d;
    bit vld, err;
    ops[0] = 8'hAA; ops[1] = 8'hBB; ops[2] = 8'hCC; ops[3] = 8'hDD;
    bus_if.RX_D_VLD = 1'b0; bus_if.RX_P_DATA = 8'h00; bus_if.RX_ERR = 1'b0;
    do_reset();
    idle(2);
    send(8'hAA); send(8'h04); send(8'hD5); idle(2);
    send(8'hBB); send(8'h05); idle(1);
    send(8'hCC); send(8'h64); send(8'h32); idle(2); send(8'h00); idle(2);
    send(8'hDD); idle(1); send(8'h02); idle(1);
    send(8'h55); idle(1);
    send(8'hAA); send(8'h04); step(1'b1, 8'hD5, 1'b1);
    send(8'hAA); send(8'h06); send(8'hA3); idle(1);
    send(8'hAA); send(8'hF7); idle(3); send(8'hAA); idle(1);
    send(8'hCC); send(8'hAA); send(8'hBB); send(8'hDD); send(8'hCC);
    send(8'hBB); do_reset(); send(8'h05); idle(1);
    send(8'hCC); idle(TMO + 3);
    send(8'hDD); idle(TMO - 1); send(8'h09); idle(2);
    step(1'b1, 8'hAA, 1'b1); idle(1);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 120) == 0) begin
        do_reset();
      end else begin
        vld = ($urandom_range(0, 9) < 6);
        err = ($urandom_range(0, 15) == 0);
        d   = $urandom_range(0, 1) ? ops[$urandom_range(0, 3)] : 8'($urandom);
        step(vld, d, err);
      end
    end
    idle(TMO + 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
